// File: rtl/ahb_apb_bridge_ctrl.sv
// AHB-to-APB bridge control: one AHB slave region mapped onto four APB slaves.
// Each accepted AHB transfer becomes a single APB SETUP/ENABLE access.
module ahb_apb_bridge_ctrl #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter logic [3:0]  REGION  = 4'h8,
    parameter int unsigned IDX_LSB = 26
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic          HREADYin,
    input  logic [AW-1:0] HADDR,
    input  logic [DW-1:0] HWDATA,
    input  logic [2:0]    HSIZE,
    output logic [DW-1:0] HRDATA,
    output logic          HREADYout,
    output logic [3:0]    PSELx,
    output logic          PENABLE,
    output logic          PWRITE,
    output logic [AW-1:0] PADDR,
    output logic [DW-1:0] PWDATA,
    input  logic [DW-1:0] PRDATA
);

    typedef enum logic [2:0] {
        StIdle, StRSetup, StREnable, StWWait, StWSetup, StWEnable
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    psel_q, psel_d;
    logic          penable_q, penable_d;
    logic          pwrite_q, pwrite_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic [DW-1:0] pwdata_q, pwdata_d;
    logic          hready_q, hready_d;
    logic          valid;

    // Every access is full width and BUSY is treated like IDLE.
    logic unused_inputs;
    assign unused_inputs = ^{HSIZE, HTRANS[0]};

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    assign valid = HREADYin & HTRANS[1] & (HADDR[AW-1 -: 4] == REGION);

    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        hready_d  = hready_q;
        case (state_q)
            // ENABLE states also act as address-phase slots so back-to-back
            // transfers need no IDLE gap.
            StIdle, StREnable, StWEnable: begin
                state_d   = StIdle;
                psel_d    = '0;
                penable_d = 1'b0;
                hready_d  = 1'b1;
                if (valid) begin
                    paddr_d  = HADDR;
                    hready_d = 1'b0;
                    if (HWRITE) begin
                        state_d = StWWait;
                    end else begin
                        state_d  = StRSetup;
                        psel_d   = onehot(HADDR[IDX_LSB+1 -: 2]);
                        pwrite_d = 1'b0;
                    end
                end
            end
            StRSetup: begin
                state_d   = StREnable;
                penable_d = 1'b1;
                hready_d  = 1'b1;
            end
            StWWait: begin
                state_d  = StWSetup;
                pwdata_d = HWDATA;
                psel_d   = onehot(paddr_q[IDX_LSB+1 -: 2]);
                pwrite_d = 1'b1;
            end
            StWSetup: begin
                state_d   = StWEnable;
                penable_d = 1'b1;
                hready_d  = 1'b1;
            end
            default: begin
                state_d   = StIdle;
                psel_d    = '0;
                penable_d = 1'b0;
                hready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q   <= StIdle;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            hready_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            hready_q  <= hready_d;
        end
    end

    assign PSELx     = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign HREADYout = hready_q;
    assign HRDATA    = (state_q == StREnable) ? PRDATA : '0;

endmodule

// File: tb/tb_ahb_apb_bridge_ctrl.sv
// Bench for ahb_apb_bridge_ctrl: an AHB master drives a transfer queue and each
// transfer is checked against expected APB access, wait states and read data.
module tb_ahb_apb_bridge_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HREADYin;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [2:0]  HSIZE;
    logic [31:0] HRDATA;
    logic        HREADYout;
    logic [3:0]  PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } xfer_t;

    xfer_t q[$];

    ahb_apb_bridge_ctrl dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HREADYin  (HREADYin),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HSIZE     (HSIZE),
        .HRDATA    (HRDATA),
        .HREADYout (HREADYout),
        .PSELx     (PSELx),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA)
    );

    always #5 HCLK = ~HCLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit in_region(input logic [31:0] a);
        return a[31:28] == 4'h8;
    endfunction

    function automatic logic [3:0] slave_sel(input logic [31:0] a);
        return 4'(1 << a[27:26]);
    endfunction

    task automatic push(input logic [1:0] tr, input logic [31:0] a, input logic w,
                        input logic [31:0] wd, input logic [31:0] rd);
        xfer_t t;
        t.trans = tr; t.addr = a; t.write = w; t.wdata = wd; t.rdata = rd;
        q.push_back(t);
    endtask

    // Acts as AHB master; drives the queue to completion and checks each transfer.
    task automatic run_xfers(input int max_cycles);
        xfer_t ap, dp, t;
        bit ap_v = 0, dp_v = 0, inr;
        int waits = 0, nsetup = 0, nen = 0, cyc = 0;
        while ((q.size() > 0 || ap_v || dp_v) && cyc < max_cycles) begin
            @(negedge HCLK);
            cyc++;
            if (ap_v) begin
                dp = ap; dp_v = 1; ap_v = 0;
                waits = 0; nsetup = 0; nen = 0;
                HWDATA = dp.wdata;
                PRDATA = dp.rdata;
            end
            #1;
            if (PSELx == 4'b0) check_eq("penable_without_psel", 32'(PENABLE), 32'd0);
            if (dp_v) begin
                inr = in_region(dp.addr);
                if (PSELx != 4'b0) begin
                    check_eq("psel", 32'(PSELx), 32'(slave_sel(dp.addr)));
                    check_eq("paddr", PADDR, dp.addr);
                    check_eq("pwrite", 32'(PWRITE), 32'(dp.write));
                    if (dp.write) check_eq("pwdata", PWDATA, dp.wdata);
                    if (PENABLE) nen++; else nsetup++;
                end
                if (HREADYout) begin
                    if (!dp.write) check_eq("hrdata", HRDATA, inr ? dp.rdata : 32'd0);
                    check_eq("wait_states", 32'(waits), inr ? (dp.write ? 32'd2 : 32'd1) : 32'd0);
                    check_eq("setup_cycles", 32'(nsetup), 32'(inr));
                    check_eq("enable_cycles", 32'(nen), 32'(inr));
                    dp_v = 0;
                end else begin
                    check_eq("hrdata_wait", HRDATA, 32'd0);
                    waits++;
                end
            end else begin
                check_eq("idle_psel", 32'(PSELx), 32'd0);
                check_eq("idle_hready", 32'(HREADYout), 32'd1);
                check_eq("idle_hrdata", HRDATA, 32'd0);
            end
            if (HREADYout) begin
                HREADYin = 1'b1;
                if (q.size() > 0) begin
                    t = q.pop_front();
                    HTRANS = t.trans; HADDR = t.addr; HWRITE = t.write;
                    if (t.trans[1]) begin ap = t; ap_v = 1; end
                end else begin
                    HTRANS = 2'b00;
                end
            end else begin
                HREADYin = 1'b0;
            end
        end
        if (cyc >= max_cycles) begin
            check_eq("timeout", 32'(cyc), 32'(max_cycles - 1));
            q.delete();
        end
    endtask

    initial begin
        HRESET = 1'b1; HTRANS = 2'b00; HWRITE = 1'b0; HREADYin = 1'b1;
        HADDR = '0; HWDATA = '0; HSIZE = 3'b010; PRDATA = 32'hA5A5_5A5A;
        repeat (3) @(negedge HCLK);
        #1;
        check_eq("rst_psel", 32'(PSELx), 32'd0);
        check_eq("rst_penable", 32'(PENABLE), 32'd0);
        check_eq("rst_pwrite", 32'(PWRITE), 32'd0);
        check_eq("rst_paddr", PADDR, 32'd0);
        check_eq("rst_pwdata", PWDATA, 32'd0);
        check_eq("rst_hready", 32'(HREADYout), 32'd1);
        check_eq("rst_hrdata", HRDATA, 32'd0);
        @(negedge HCLK);
        HRESET = 1'b0;

        // Directed: single read, single write, write->read back-to-back, out of range.
        push(2'b10, 32'h8400_0010, 1'b0, 32'h0, 32'hDEAD_BEEF);
        push(2'b00, 32'h0, 1'b0, 32'h0, 32'h0);
        push(2'b10, 32'h8800_0004, 1'b1, 32'h1234_5678, 32'h0);
        push(2'b00, 32'h0, 1'b0, 32'h0, 32'h0);
        push(2'b10, 32'h8C00_0000, 1'b1, 32'hCAFE_F00D, 32'h0);
        push(2'b10, 32'h8000_0008, 1'b0, 32'h0, 32'h0BAD_F00D);
        push(2'b10, 32'h4000_0000, 1'b0, 32'h0, 32'h7777_7777);
        push(2'b11, 32'h8000_0100, 1'b0, 32'h0, 32'h1357_9BDF);
        run_xfers(100);

        // BUSY and HREADYin=0 with an in-range address must be ignored.
        @(negedge HCLK);
        HTRANS = 2'b01; HADDR = 32'h8000_0000; HWRITE = 1'b0; HREADYin = 1'b1;
        @(negedge HCLK); #1;
        check_eq("busy_psel", 32'(PSELx), 32'd0);
        check_eq("busy_hready", 32'(HREADYout), 32'd1);
        HTRANS = 2'b10; HREADYin = 1'b0;
        @(negedge HCLK); #1;
        check_eq("nordy_psel", 32'(PSELx), 32'd0);
        check_eq("nordy_hready", 32'(HREADYout), 32'd1);
        HTRANS = 2'b00; HREADYin = 1'b1;
        @(negedge HCLK); #1;
        check_eq("nordy_psel2", 32'(PSELx), 32'd0);
        check_eq("nordy_penable", 32'(PENABLE), 32'd0);

        // Reset asserted during RENABLE drops the access immediately.
        HTRANS = 2'b10; HADDR = 32'h8800_0020; HWRITE = 1'b0; PRDATA = 32'h5555_AAAA;
        begin
            bit seen = 0;
            for (int i = 0; i < 5 && !seen; i++) begin
                @(negedge HCLK);
                HTRANS = 2'b00;
                #1;
                if (PENABLE) seen = 1;
            end
            check_eq("reach_renable", 32'(seen), 32'd1);
        end
        HRESET = 1'b1;
        #1;
        check_eq("arst_psel", 32'(PSELx), 32'd0);
        check_eq("arst_penable", 32'(PENABLE), 32'd0);
        check_eq("arst_hready", 32'(HREADYout), 32'd1);
        check_eq("arst_hrdata", HRDATA, 32'd0);
        check_eq("arst_paddr", PADDR, 32'd0);
        @(negedge HCLK);
        HRESET = 1'b0;
        push(2'b10, 32'h8400_0010, 1'b0, 32'h0, 32'h0F0F_1234);
        run_xfers(20);

        // Randomized mix of reads, writes, idle/busy cycles and out-of-range hits.
        for (int i = 0; i < 300; i++) begin
            int kind = $urandom_range(0, 99);
            logic [31:0] a = $urandom();
            logic [1:0] tr;
            if (kind < 10) tr = 2'b00;
            else if (kind < 20) tr = 2'b01;
            else tr = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
            if ($urandom_range(0, 9) < 8) a[31:28] = 4'h8;
            push(tr, a, 1'($urandom_range(0, 1)), $urandom(), $urandom());
        end
        run_xfers(2000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
